// File: rtl/parity_lane_calc_if.sv
// rtl/parity_lane_calc_if.sv - word/config handshake and parity result bundle
interface parity_lane_calc_if #(
  parameter int IN_WIDTH   = 16,
  parameter int LANE_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  localparam int LANES = IN_WIDTH / LANE_WIDTH;

  logic [IN_WIDTH-1:0]  DATA;
  logic                 Data_Valid;
  logic                 Data_Last;
  logic                 busy;
  logic                 parity_enable;
  logic [1:0]           parity_mode;
  logic                 accum_mode;
  logic [LANES-1:0]     parity;
  logic                 parity_valid;
  logic [CNT_WIDTH-1:0] word_count;

  modport master (
    output DATA, Data_Valid, Data_Last, busy, parity_enable, parity_mode, accum_mode,
    input  parity, parity_valid, word_count
  );

  modport slave (
    input  DATA, Data_Valid, Data_Last, busy, parity_enable, parity_mode, accum_mode,
    output parity, parity_valid, word_count
  );
endinterface

// File: rtl/parity_lane_calc.sv
// rtl/parity_lane_calc.sv - per-lane parity with optional accumulation over a packet
module parity_lane_calc #(
  parameter int IN_WIDTH   = 16,
  parameter int LANE_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input logic               CLK,
  input logic               RST,
  parity_lane_calc_if.slave bus
);
  localparam int LANES = IN_WIDTH / LANE_WIDTH;

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  state_t               r_state;
  logic [IN_WIDTH-1:0]  r_data;
  logic                 r_last;
  logic                 r_go;
  logic                 r_cfg_en;
  logic [1:0]           r_cfg_mode;
  logic                 r_cfg_accum;
  logic [LANES-1:0]     r_acc;
  logic [CNT_WIDTH-1:0] r_count;
  logic [LANES-1:0]     r_parity;
  logic                 r_parity_valid;
  logic [CNT_WIDTH-1:0] r_word_count;

  logic                 w_accept;
  logic [LANES-1:0]     w_lane_x;
  logic [LANES-1:0]     w_acc_next;
  logic [LANES-1:0]     w_result;
  logic                 w_emit;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] w_count_inc;

  assign w_accept = bus.Data_Valid && !bus.busy;

  always_comb begin
    w_lane_x = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_x[k] = ^r_data[k*LANE_WIDTH +: LANE_WIDTH];
    end
    w_acc_next = r_acc ^ w_lane_x;

    case (r_cfg_mode)
      2'b00:   w_result = w_acc_next;
      2'b01:   w_result = ~w_acc_next;
      2'b10:   w_result = '1;
      default: w_result = '0;
    endcase

    w_count_inc = (r_count == '1) ? r_count : r_count + CNT_WIDTH'(1);

    // Data_Last only ends a packet when accumulating; per-word mode always emits
    w_emit       = 1'b0;
    w_state_next = r_state;
    if (r_go) begin
      if (r_state == ST_IDLE) begin
        w_emit       = !r_cfg_accum || r_last;
        w_state_next = w_emit ? ST_IDLE : ST_ACCUM;
      end else begin
        w_emit       = r_last;
        w_state_next = r_last ? ST_IDLE : ST_ACCUM;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state        <= ST_IDLE;
      r_data         <= '0;
      r_last         <= 1'b0;
      r_go           <= 1'b0;
      r_cfg_en       <= 1'b0;
      r_cfg_mode     <= 2'b00;
      r_cfg_accum    <= 1'b0;
      r_acc          <= '0;
      r_count        <= '0;
      r_parity       <= '0;
      r_parity_valid <= 1'b0;
      r_word_count   <= '0;
    end else begin
      r_parity_valid <= 1'b0;
      r_go           <= w_accept;

      if (w_accept) begin
        r_data <= bus.DATA;
        r_last <= bus.Data_Last;
        // Config belongs to the first word of a packet, judged after this edge's transition
        if (w_state_next == ST_IDLE) begin
          r_cfg_en    <= bus.parity_enable;
          r_cfg_mode  <= bus.parity_mode;
          r_cfg_accum <= bus.accum_mode;
        end
      end

      if (r_go) begin
        r_state <= w_state_next;
        if (w_emit) begin
          r_acc   <= '0;
          r_count <= '0;
          if (r_cfg_en) begin
            r_parity       <= w_result;
            r_word_count   <= w_count_inc;
            r_parity_valid <= 1'b1;
          end
        end else begin
          r_acc   <= w_acc_next;
          r_count <= w_count_inc;
        end
      end
    end
  end

  assign bus.parity       = r_parity;
  assign bus.parity_valid = r_parity_valid;
  assign bus.word_count   = r_word_count;
endmodule

// File: tb/tb_parity_lane_calc.sv
// tb/tb_parity_lane_calc.sv - scoreboard bench for parity_lane_calc
module tb_parity_lane_calc;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  typedef struct {
    logic [1:0] p;
    logic [7:0] wc;
    int         at;
  } exp_t;

  exp_t sb[$];

  parity_lane_calc_if #(.IN_WIDTH(16), .LANE_WIDTH(8), .CNT_WIDTH(8)) bus ();

  parity_lane_calc #(.IN_WIDTH(16), .LANE_WIDTH(8), .CNT_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe is matched against the oldest expected result
  always @(negedge clk) begin
    if (rst && bus.parity_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got parity %0h wc %0d want none", bus.parity, bus.word_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("parity", int'(bus.parity), int'(e.p));
        check("word_count", int'(bus.word_count), int'(e.wc));
        check("strobe_cycle", cyc, e.at);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic last, input logic en,
                      input logic [1:0] mode, input logic accum,
                      input bit expect_out, input logic [1:0] ep, input logic [7:0] ewc);
    exp_t e;
    bus.DATA          = d;
    bus.Data_Last     = last;
    bus.parity_enable = en;
    bus.parity_mode   = mode;
    bus.accum_mode    = accum;
    bus.Data_Valid    = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    if (expect_out) begin
      e.p  = ep;
      e.wc = ewc;
      e.at = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus.DATA          = 16'h0705;
    bus.Data_Valid    = 1'b1;
    bus.Data_Last     = 1'b1;
    bus.busy          = 1'b0;
    bus.parity_enable = 1'b1;
    bus.parity_mode   = 2'b00;
    bus.accum_mode    = 1'b0;

    // Reset with a word offered: nothing may be captured
    @(negedge clk);
    @(negedge clk);
    check("reset_parity", int'(bus.parity), 0);
    check("reset_valid", int'(bus.parity_valid), 0);
    check("reset_wc", int'(bus.word_count), 0);
    bus.Data_Valid = 1'b0;
    rst = 1'b1;
    idle(3);

    // Per-word even/odd, then back-to-back last words
    send(16'h0705, 1'b1, 1'b1, 2'b00, 1'b0, 1, 2'b10, 8'd1);
    idle(2);
    send(16'h0705, 1'b1, 1'b1, 2'b01, 1'b0, 1, 2'b01, 8'd1);
    idle(2);
    send(16'h0705, 1'b0, 1'b1, 2'b00, 1'b0, 1, 2'b10, 8'd1);
    send(16'h0705, 1'b0, 1'b1, 2'b01, 1'b0, 1, 2'b01, 8'd1);
    idle(2);

    // Packet accumulate; mid-packet config changes must be ignored
    send(16'h0103, 1'b0, 1'b1, 2'b00, 1'b1, 0, 2'b00, 8'd0);
    send(16'h0001, 1'b0, 1'b0, 2'b01, 1'b0, 0, 2'b00, 8'd0);
    send(16'h8000, 1'b1, 1'b0, 2'b10, 1'b0, 1, 2'b01, 8'd3);
    idle(2);

    // busy holds the word off for three cycles
    bus.busy          = 1'b1;
    bus.DATA          = 16'hFFFF;
    bus.Data_Last     = 1'b1;
    bus.parity_enable = 1'b1;
    bus.parity_mode   = 2'b00;
    bus.accum_mode    = 1'b0;
    bus.Data_Valid    = 1'b1;
    idle(3);
    bus.busy = 1'b0;
    send(16'hFFFF, 1'b1, 1'b1, 2'b00, 1'b0, 1, 2'b00, 8'd1);
    idle(2);

    // Mark, space, then disabled
    send(16'h0705, 1'b1, 1'b1, 2'b10, 1'b0, 1, 2'b11, 8'd1);
    idle(2);
    send(16'h0705, 1'b1, 1'b1, 2'b11, 1'b0, 1, 2'b00, 8'd1);
    idle(2);
    send(16'h0705, 1'b1, 1'b0, 2'b00, 1'b0, 0, 2'b00, 8'd0);
    idle(3);
    check("disabled_parity_hold", int'(bus.parity), 0);
    check("disabled_wc_hold", int'(bus.word_count), 1);

    // Reset mid-packet abandons it; next word starts at count 1
    send(16'h0103, 1'b0, 1'b1, 2'b00, 1'b1, 0, 2'b00, 8'd0);
    send(16'h0001, 1'b0, 1'b1, 2'b00, 1'b1, 0, 2'b00, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    send(16'h0001, 1'b1, 1'b1, 2'b00, 1'b1, 1, 2'b01, 8'd1);
    idle(2);

    // Counter saturation over a 300-word odd packet
    for (int i = 0; i < 299; i++) begin
      send(16'h0101, 1'b0, 1'b1, 2'b01, 1'b1, 0, 2'b00, 8'd0);
    end
    send(16'h0101, 1'b1, 1'b1, 2'b01, 1'b1, 1, 2'b11, 8'd255);

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parity_lane_calc.md
# parity_lane_calc

Parametrised successor to the single-word parity calculator in the UART TX path. It computes one parity bit per lane of a multi-lane data word. It supports even, odd, mark and space modes, and can accumulate parity across a multi-word packet. Words are accepted through a valid/busy handshake from the frame builder; the result goes to the serializer with a one-cycle valid strobe.

## Interface
- IN_WIDTH, 16: input word width; must be an integer multiple of LANE_WIDTH.
- LANE_WIDTH, 8: bits per parity lane. LANES = IN_WIDTH/LANE_WIDTH (derived). Lane k = DATA[k*LANE_WIDTH +: LANE_WIDTH].
- CNT_WIDTH, 8: width of the packet word counter.

Ports:
- CLK  in  1: sole clock, rising edge.
- RST  in  1: synchronous, active-low reset.
- DATA  in  IN_WIDTH: input word.
- Data_Valid  in  1: DATA and the config inputs are presented this cycle.
- Data_Last  in  1: qualifies Data_Valid; marks the final word of a packet.
- busy  in  1: downstream busy; blocks acceptance.
- parity_enable  in  1: 0 = no parity is produced.
- parity_mode  in  2: 00 even, 01 odd, 10 mark (all 1), 11 space (all 0).
- accum_mode  in  1: 0 = per-word result; 1 = running result over a packet, ending at Data_Last.
- parity  out  LANES: per-lane parity result; bit k belongs to lane k.
- parity_valid  out  1: one-cycle strobe when parity is updated.
- word_count  out  CNT_WIDTH: number of words in the reported result.

## Operation
- Accept: a word is accepted when Data_Valid=1 and busy=0 at a rising edge. Otherwise nothing is captured, and the source holds its inputs.
- Stage 1 (accept edge): DATA goes into DATA_reg, Data_Last into last_reg, and a go flag is set.
  - parity_enable, parity_mode and accum_mode are captured only when the FSM is in IDLE (first word of a packet).
  - These config values are held until the packet ends. Changing them mid-packet has no effect.
- Stage 2 (next edge, when go is set): lane_x[k] = XOR-reduction of lane k of DATA_reg, and acc_next = acc ^ lane_x. The result is then formed from acc_next by mode:
  - even: parity = acc_next.
  - odd: parity = ~acc_next.
  - mark: all ones.
  - space: all zeros.
- FSM states: IDLE and ACCUM.
  - IDLE, word processed with accum_mode=0 or last_reg=1: emit the result, set acc=0 and count=0, stay in IDLE.
  - IDLE, word processed with accum_mode=1 and last_reg=0: acc <= acc_next, count <= 1, go to ACCUM.
  - ACCUM, word processed with last_reg=0: acc <= acc_next, count increments.
  - ACCUM, word processed with last_reg=1: emit the result, clear acc and count, go to IDLE.
- Emit:
  - With parity_enable=1: parity <= result, word_count <= count+1, and parity_valid pulses high for exactly one cycle.
  - With parity_enable=0: the packet is consumed normally, but parity and word_count hold their previous values and parity_valid stays 0.
- The counter saturates at 2^CNT_WIDTH-1; it does not wrap.
- busy affects acceptance only. A word already in stage 1 always completes stage 2.

## Timing
- Reset (RST=0 at an edge): parity=0, parity_valid=0, word_count=0, FSM=IDLE. DATA_reg, acc, count, go and the config registers are all cleared.
- Reset has priority over everything, including acceptance in the same cycle.
- Latency: a word accepted at edge N produces a result at edge N+1. parity and parity_valid are visible after edge N+1.
- Throughput: one word per cycle. Back-to-back last words give parity_valid high on consecutive cycles, each cycle carrying a fresh result.
- Packet emit: parity_valid fires only for the Data_Last word; intermediate words produce no strobe.
- Simultaneous events: a new accept at edge N+1, while stage 2 processes the previous word, is legal. The new word's first-word config capture uses the FSM state after edge N+1's transition.
- Reset mid-packet: the packet is abandoned with no strobe. The next accepted word starts a new packet at count 1.
- Data_Last with accum_mode=0 is ignored; every word emits.
- Outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset: hold RST=0 for 1 cycle with Data_Valid=1 → parity=2'b00, parity_valid=0, word_count=0, and nothing is accepted.
- Per-word even/odd (IN_WIDTH=16, LANE_WIDTH=8):
  - DATA=16'h0705, mode 00, accum 0 → one cycle after the accept edge, parity=2'b10, a single parity_valid pulse, word_count=1.
  - Same DATA with mode 01 → parity=2'b01.
- Packet accumulate: even mode, words 16'h0103, 16'h0001, then 16'h8000 with Data_Last → exactly one strobe, after the third word, with parity=2'b01 and word_count=3.
- busy hold: DATA=16'hFFFF, Data_Valid=1, busy=1 for 3 cycles → no strobe. Drop busy → accepted, and next cycle parity=2'b00 with one strobe.
- Mark/space/disable:
  - mode 10 → parity=2'b11.
  - mode 11 → parity=2'b00.
  - Then parity_enable=0 with any DATA → parity stays 2'b00 and no strobe.
- Reset mid-packet: 2 accumulate words, then RST=0 for 1 cycle → no strobe. Next single last word 16'h0001, even → parity=2'b01, word_count=1.
